// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file (Status, Cause, EPC, BadVAddr,
// Count, Compare) with the Count timer, the timer interrupt and exception
// commit from the memory stage.
module cp0_regfile #(
    parameter logic [4:0] EXC_NONE = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [4:0]  exception_code_i,
    input  logic        eret_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] EXC_ADEL      = 5'd4;
    localparam logic [4:0] EXC_ADES      = 5'd5;

    // Only the architecturally writable fields are stored; constant bits are
    // stitched in when the registers are presented.
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;
    logic        timer_int;

    logic exc_valid;
    logic mtc0_shared;
    logic addr_err;

    // Exception outranks ERET, which outranks MTC0 on Status/Cause/EPC.
    assign exc_valid   = (exception_code_i != EXC_NONE);
    assign mtc0_shared = we_i && !exc_valid && !eret_i;
    assign addr_err    = exc_valid &&
                         ((exception_code_i == EXC_ADEL) || (exception_code_i == EXC_ADES));

    // Status: IM/EXL/IE, EXL driven by exception entry and ERET.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im  <= 8'd0;
            exl <= 1'b0;
            ie  <= 1'b0;
        end else if (exc_valid) begin
            exl <= 1'b1;
        end else if (eret_i) begin
            exl <= 1'b0;
        end else if (mtc0_shared && (waddr_i == ADDR_STATUS)) begin
            im  <= data_i[15:8];
            exl <= data_i[1];
            ie  <= data_i[0];
        end
    end

    // Cause: hardware IP resampled each cycle, software IP, ExcCode and BD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_hw    <= 6'd0;
            ip_sw    <= 2'd0;
            exc_code <= 5'd0;
            bd       <= 1'b0;
        end else begin
            ip_hw <= {int_i[5] | timer_int, int_i[4:0]};
            if (exc_valid) begin
                exc_code <= exception_code_i;
                if (!exl) begin
                    bd <= is_in_delayslot_i;
                end
            end else if (mtc0_shared && (waddr_i == ADDR_CAUSE)) begin
                ip_sw <= data_i[9:8];
            end
        end
    end

    // EPC: captured only on the first exception of a nest (EXL clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= 32'd0;
        end else if (exc_valid) begin
            if (!exl) begin
                epc <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            end
        end else if (mtc0_shared && (waddr_i == ADDR_EPC)) begin
            epc <= data_i;
        end
    end

    // BadVAddr: address-error exceptions take precedence over an MTC0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr <= 32'd0;
        end else if (addr_err) begin
            badvaddr <= badvaddr_i;
        end else if (we_i && (waddr_i == ADDR_BADVADDR)) begin
            badvaddr <= data_i;
        end
    end

    // Count: advances every other cycle; an MTC0 reloads it and restarts the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
            tick  <= 1'b0;
        end else if (we_i && (waddr_i == ADDR_COUNT)) begin
            count <= data_i;
            tick  <= 1'b0;
        end else begin
            tick <= ~tick;
            if (tick) begin
                count <= count + 32'd1;
            end
        end
    end

    // Compare and the sticky timer interrupt; writing Compare clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare   <= 32'd0;
            timer_int <= 1'b0;
        end else if (we_i && (waddr_i == ADDR_COMPARE)) begin
            compare   <= data_i;
            timer_int <= 1'b0;
        end else if ((compare != 32'd0) && (count == compare)) begin
            timer_int <= 1'b1;
        end
    end

    assign status_o    = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    assign cause_o     = {bd, timer_int, 14'd0, ip_hw, ip_sw, 1'b0, exc_code, 2'd0};
    assign epc_o       = epc;
    assign badvaddr_o  = badvaddr;
    assign count_o     = count;
    assign compare_o   = compare;
    assign timer_int_o = timer_int;

    // MFC0 read mux on current register state.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            ADDR_BADVADDR: data_o = badvaddr_o;
            ADDR_COUNT:    data_o = count_o;
            ADDR_COMPARE:  data_o = compare_o;
            ADDR_STATUS:   data_o = status_o;
            ADDR_CAUSE:    data_o = cause_o;
            ADDR_EPC:      data_o = epc_o;
            default:       data_o = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed and randomized checks of cp0_regfile against a
// field-level reference model of the CP0 registers.
module tb_cp0_regfile;
    localparam logic [4:0] EXC_NONE = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [4:0]  raddr = 5'd12;
    logic [31:0] wdata = 32'd0;
    logic [5:0]  int_lines = 6'd0;
    logic [4:0]  exc_code = EXC_NONE;
    logic        eret = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        ds = 1'b0;
    logic [31:0] bad = 32'd0;

    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: full 32-bit register images (Cause without TI).
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_cmp;
    logic        m_timer, m_phase;

    cp0_regfile #(.EXC_NONE(EXC_NONE)) dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr),
        .data_i(wdata), .int_i(int_lines), .exception_code_i(exc_code),
        .eret_i(eret), .pc_i(pc), .is_in_delayslot_i(ds), .badvaddr_i(bad),
        .data_o(data_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_cause();
        return m_cause | (m_timer ? 32'h4000_0000 : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return model_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_cause = 0; m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
        m_timer = 1'b0; m_phase = 1'b0;
    endtask

    // Next state from the pre-edge model state and the inputs held across the edge.
    task automatic model_step();
        logic exc, old_exl, wr_count, wr_cmp;
        logic [31:0] ns, nc, ne, nb, ncnt, ncmp;
        logic nt, nph;
        exc = (exc_code != EXC_NONE);
        old_exl = m_status[1];
        ns = m_status; nc = m_cause; ne = m_epc; nb = m_bad;
        ncnt = m_count; ncmp = m_cmp; nt = m_timer; nph = m_phase;
        wr_count = we && (waddr == 5'd9);
        wr_cmp = we && (waddr == 5'd11);
        if (exc) begin
            ns[1] = 1'b1;
            nc[6:2] = exc_code;
            if (!old_exl) begin
                ne = ds ? pc - 32'd4 : pc;
                nc[31] = ds;
            end
        end else if (eret) begin
            ns[1] = 1'b0;
        end else if (we) begin
            if (waddr == 5'd12) ns = (wdata & 32'h0000_FF03) | 32'h0040_0000;
            if (waddr == 5'd13) nc = (m_cause & ~32'h0000_0300) | (wdata & 32'h0000_0300);
            if (waddr == 5'd14) ne = wdata;
        end
        if (exc && (exc_code == 5'd4 || exc_code == 5'd5)) nb = bad;
        else if (we && waddr == 5'd8) nb = wdata;
        nc[15:10] = {int_lines[5] | m_timer, int_lines[4:0]};
        if (wr_count) begin
            ncnt = wdata; nph = 1'b0;
        end else begin
            if (m_phase) ncnt = m_count + 32'd1;
            nph = ~m_phase;
        end
        if (wr_cmp) begin
            ncmp = wdata; nt = 1'b0;
        end else if (m_cmp != 0 && m_count == m_cmp) begin
            nt = 1'b1;
        end
        m_status = ns; m_cause = nc; m_epc = ne; m_bad = nb;
        m_count = ncnt; m_cmp = ncmp; m_timer = nt; m_phase = nph;
    endtask

    task automatic check_all();
        chk("status", status_o, m_status);
        chk("cause", cause_o, model_cause());
        chk("epc", epc_o, m_epc);
        chk("badvaddr", badvaddr_o, m_bad);
        chk("count", count_o, m_count);
        chk("compare", compare_o, m_cmp);
        chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
        chk("data_o", data_o, model_read(raddr));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'd0; int_lines = 6'd0;
        exc_code = EXC_NONE; eret = 1'b0; pc = 32'd0; ds = 1'b0; bad = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we = 1'b1; waddr = a; wdata = d;
        cycle();
        idle();
    endtask

    task automatic except(input logic [4:0] code, input logic [31:0] p,
                          input logic d, input logic [31:0] b);
        idle();
        exc_code = code; pc = p; ds = d; bad = b;
        cycle();
        idle();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_status"}, status_o, 32'h0040_0000);
        chk({tag, "_cause"}, cause_o, 32'h0);
        chk({tag, "_epc"}, epc_o, 32'h0);
        chk({tag, "_bad"}, badvaddr_o, 32'h0);
        chk({tag, "_count"}, count_o, 32'h0);
        chk({tag, "_compare"}, compare_o, 32'h0);
        chk({tag, "_timer"}, {31'd0, timer_int_o}, 32'h0);
        chk({tag, "_data"}, data_o, 32'h0040_0000);
    endtask

    initial begin
        logic seen;
        int r;
        model_reset();
        #3;
        reset_checks("por");
        #9 rst = 1'b0;

        // First increments after reset release.
        cycle(); cycle();
        chk("count_first", count_o, 32'd1);
        cycle(); cycle();
        chk("count_second", count_o, 32'd2);

        // Write masking on Status and Cause.
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cause_o, 32'h0000_0300);
        mtc0(5'd12, 32'h0);
        chk("status_clear", status_o, 32'h0040_0000);

        // Delay-slot exception, then a nested one.
        except(5'h0C, 32'hBFC0_0104, 1'b1, 32'h0);
        chk("ds_epc", epc_o, 32'hBFC0_0100);
        chk("ds_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("ds_code", {27'd0, cause_o[6:2]}, 32'h0C);
        chk("ds_exl", {31'd0, status_o[1]}, 32'd1);
        except(5'h0A, 32'h8000_0000, 1'b0, 32'h0);
        chk("nest_epc", epc_o, 32'hBFC0_0100);
        chk("nest_code", {27'd0, cause_o[6:2]}, 32'h0A);

        // Address error captures BadVAddr; other codes leave it alone.
        except(5'd4, 32'h100, 1'b0, 32'h1234_5671);
        chk("adel_bad", badvaddr_o, 32'h1234_5671);
        except(5'h08, 32'h100, 1'b0, 32'hFFFF_0000);
        chk("sys_bad", badvaddr_o, 32'h1234_5671);

        // ERET colliding with MTC0 Status: EXL clears, IE untouched.
        idle(); eret = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0003;
        cycle(); idle();
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret_ie", {31'd0, status_o[0]}, 32'd0);

        // Exception colliding with MTC0 EPC: exception value wins.
        idle(); exc_code = 5'h0D; pc = 32'h0000_1000; we = 1'b1; waddr = 5'd14;
        wdata = 32'hDEAD_BEEF;
        cycle(); idle();
        chk("exc_epc_win", epc_o, 32'h0000_1000);
        idle(); eret = 1'b1; cycle(); idle();

        // Timer interrupt at count==compare, cleared by a Compare write.
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            if (timer_int_o) seen = 1'b1;
        end
        chk("timer_set", {31'd0, timer_int_o}, 32'd1);
        chk("timer_count", count_o, 32'd10);
        chk("timer_ti", {31'd0, cause_o[30]}, 32'd1);
        cycle();
        chk("timer_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd50);
        chk("timer_clear", {31'd0, timer_int_o}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 6);
            case (r)
                0: waddr = 5'd8;
                1: waddr = 5'd9;
                2: waddr = 5'd11;
                3: waddr = 5'd12;
                4: waddr = 5'd13;
                5: waddr = 5'd14;
                default: waddr = 5'($urandom_range(0, 31));
            endcase
            wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 24));
            raddr = 5'($urandom_range(0, 16));
            int_lines = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            r = $urandom_range(0, 15);
            if (r < 10) exc_code = EXC_NONE;
            else if (r < 12) exc_code = 5'($urandom_range(4, 5));
            else exc_code = 5'($urandom_range(0, 30));
            eret = ($urandom_range(0, 7) == 0);
            pc = 32'($urandom);
            ds = 1'($urandom_range(0, 1));
            bad = 32'($urandom);
            cycle();
        end
        idle();

        // Asynchronous reset in the middle of a cycle.
        raddr = 5'd12;
        exc_code = 5'd4; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        #1 rst = 1'b1;
        #1;
        reset_checks("async");
        model_reset();
        idle();
        @(posedge clk);
        #3 rst = 1'b0;
        cycle(); cycle();
        chk("rst_count1", count_o, 32'd1);
        cycle(); cycle();
        chk("rst_count2", count_o, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
